fir_tap_multiplier: RTL

//  Producer side of the fir_adder_tree products interface. Holds a 16-tap sample delay line and
//  16 signed coefficients, computes the 16 full-precision tap products per accepted sample, and

---
 rtl/fir_tap_multiplier_if.sv | 25 ++
 rtl/fir_tap_multiplier.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fir_tap_multiplier_if.sv
// Sample-in / products-out bundle of the FIR tap multiplier.
// The slave modport is the multiplier; the master modport is its environment.
interface fir_tap_multiplier_if #(
  parameter int IN_WIDTH    = 12,
  parameter int COEFF_WIDTH = 16
);
  localparam int PROD_WIDTH = IN_WIDTH + COEFF_WIDTH;

  logic signed [IN_WIDTH-1:0] in_sample;
  logic                       in_valid;
  logic                       in_ready;
  logic                       flush;
  logic [16*PROD_WIDTH-1:0]   products_out;
  logic                       prod_valid;

  modport master (
    output in_sample, in_valid, flush,
    input  in_ready, products_out, prod_valid
  );

  modport slave (
    input  in_sample, in_valid, flush,
    output in_ready, products_out, prod_valid
  );
endinterface

// File: rtl/fir_tap_multiplier.sv
// 16-tap delay line and tap multipliers feeding the FIR adder tree.
// Define FIR_COEFF_WR_EN for writable, double-buffered coefficients with a drain-then-swap commit.
module fir_tap_multiplier #(
  parameter int                      IN_WIDTH    = 12,
  parameter int                      COEFF_WIDTH = 16,
  parameter logic [16*COEFF_WIDTH-1:0] COEFF_INIT = '0
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef FIR_COEFF_WR_EN
  input  logic                          coef_wr_en,
  input  logic [3:0]                    coef_wr_addr,
  input  logic signed [COEFF_WIDTH-1:0] coef_wr_data,
  input  logic                          coef_commit,
  output logic                          coef_busy,
`endif
  fir_tap_multiplier_if.slave           io
);

  localparam int NTAPS      = 16;
  localparam int PROD_WIDTH = IN_WIDTH + COEFF_WIDTH;

  typedef logic signed [IN_WIDTH-1:0]    sample_t;
  typedef logic signed [COEFF_WIDTH-1:0] coef_t;
  typedef logic signed [PROD_WIDTH-1:0]  prod_t;

  function automatic coef_t init_coef(input int k);
    return coef_t'(COEFF_INIT[(NTAPS-k)*COEFF_WIDTH-1 -: COEFF_WIDTH]);
  endfunction

  sample_t x           [NTAPS];
  coef_t   coef_active [NTAPS];
  prod_t   prod        [NTAPS];
  logic    va;
  logic    pv;
  logic    run_q;
  logic    accept;

  assign io.in_ready   = run_q & ~io.flush;
  assign accept        = io.in_valid & io.in_ready;
  assign io.prod_valid = pv;

  // Stage A: delay line. Flush wins over an offered sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) x[k] <= '0;
      va <= 1'b0;
    end else if (io.flush) begin
      for (int k = 0; k < NTAPS; k++) x[k] <= '0;
      va <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every tap read the pre-edge value of its neighbour, so the loop shifts rather than smears.
      if (accept) begin
        x[0] <= io.in_sample;
        for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
      end
      va <= accept;
    end
  end

  // Stage B: full-precision products; the registers only move on a valid, so outputs hold between valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) prod[k] <= '0;
      pv <= 1'b0;
    end else begin
      pv <= va & ~io.flush;
      if (va && !io.flush) begin
        for (int k = 0; k < NTAPS; k++)
          prod[k] <= prod_t'(x[k]) * prod_t'(coef_active[k]);
      end
    end
  end

  // NOTE: the output vector gets a default before the loop so no bit can be left unassigned and infer a latch.
  always_comb begin
    io.products_out = '0;
    for (int k = 0; k < NTAPS; k++)
      io.products_out[(NTAPS-k)*PROD_WIDTH-1 -: PROD_WIDTH] = prod[k];
  end

`ifdef FIR_COEFF_WR_EN
  typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

  state_t state;
  coef_t  coef_shadow [NTAPS];
  logic   busy_q;

  assign coef_busy = busy_q;

  // Commit waits until both pipeline stages are empty, so no sample straddles two coefficient sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: both coefficient banks are reset because the datapath must multiply by COEFF_INIT straight out of reset.
      for (int k = 0; k < NTAPS; k++) begin
        coef_active[k] <= init_coef(k);
        coef_shadow[k] <= init_coef(k);
      end
      state  <= RUN;
      run_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      if (coef_wr_en) coef_shadow[coef_wr_addr] <= coef_wr_data;
      unique case (state)
        RUN: begin
          if (coef_commit) begin
            state  <= DRAIN;
            run_q  <= 1'b0;
            busy_q <= 1'b1;
          end else begin
            run_q  <= 1'b1;
          end
        end
        DRAIN: begin
          if (!va && !pv) state <= SWAP;
        end
        SWAP: begin
          for (int k = 0; k < NTAPS; k++) coef_active[k] <= coef_shadow[k];
          state  <= RUN;
          run_q  <= 1'b1;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= RUN;
          run_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
`else
  always_comb begin
    for (int k = 0; k < NTAPS; k++) coef_active[k] = init_coef(k);
  end

  always_ff @(posedge clk) begin
    if (rst) run_q <= 1'b0;
    else     run_q <= 1'b1;
  end
`endif

endmodule
